// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg
// Shared types and defaults for the SD block-channel arbiter.
//   state_t  : arbiter FSM states
//   dir_t    : captured transfer direction
//   ptr_width: width of a requester index / round-robin pointer
package sd_arb_pkg;

    localparam int SD_ARB_NREQ  = 3;
    localparam int SD_ARB_LBA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_arb_rr_pick.sv
// sd_arb_rr_pick
// Combinational round-robin picker: first pending index at or after the
// pointer, wrapping to index 0.
//   i_pending : pending request vector
//   i_ptr     : round-robin start index
//   o_pick    : one-hot chosen requester
//   o_idx     : chosen requester index
//   o_valid   : at least one request pending
module sd_arb_rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NREQ  = SD_ARB_NREQ,
    parameter int PTR_W = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]  i_pending,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_pick,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    // Two ascending passes: the first only considers indices >= pointer,
    // the second covers the wrap-around. First hit wins.
    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!o_valid && i_pending[j] && (PTR_W'(j) >= i_ptr)) begin
                o_valid   = 1'b1;
                o_pick[j] = 1'b1;
                o_idx     = PTR_W'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!o_valid && i_pending[j]) begin
                o_valid   = 1'b1;
                o_pick[j] = 1'b1;
                o_idx     = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter
// Shares the single hps_io SD block channel between NREQ requesters,
// one block transfer at a time, round-robin.
//   clk_sys, reset      : clock, async active-high reset
//   req_rd/req_wr       : per-requester request pulses, req_lba sampled with them
//   req_done/req_err    : per-requester completion / watchdog-abort pulses
//   pending, grant, busy: status; grant is one-hot owner of the sector buffer
//   sd_lba/sd_rd/sd_wr  : channel to hps_io, sd_ack is its acknowledge
// Optional feature: define SD_ARB_TIMEOUT_EN to enable the ISSUE/XFER watchdog.
//
// state    | meaning
// ST_IDLE  | waiting for a pending request with sd_ack low
// ST_ISSUE | strobe held until hps_io raises sd_ack
// ST_XFER  | transfer in progress, waiting for sd_ack to fall
// ST_DONE  | one-cycle req_done pulse, release grant, advance pointer
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ           = SD_ARB_NREQ,
    parameter int LBA_W          = SD_ARB_LBA_W,
    parameter int TIMEOUT_CYCLES = 28000000
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_rd,
    input  logic [NREQ-1:0]       req_wr,
    input  logic [NREQ*LBA_W-1:0] req_lba,
    output logic [NREQ-1:0]       req_done,
    output logic [NREQ-1:0]       req_err,
    output logic [NREQ-1:0]       pending,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [31:0]           sd_lba,
    output logic [NREQ-1:0]       sd_rd,
    output logic [NREQ-1:0]       sd_wr,
    input  logic                  sd_ack
);

    localparam int PTR_W = ptr_width(NREQ);

    state_t             r_state;
    logic [NREQ-1:0]    r_pending;
    logic [LBA_W-1:0]   r_lba [NREQ];
    dir_t               r_dir [NREQ];
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_idx;
    logic [NREQ-1:0]    r_grant;
    logic [31:0]        r_sd_lba;
    logic [NREQ-1:0]    r_sd_rd;
    logic [NREQ-1:0]    r_sd_wr;
    logic               r_ack_q;

    logic [NREQ-1:0]    w_pick;
    logic [PTR_W-1:0]   w_idx;
    logic               w_valid;
    logic [NREQ-1:0]    w_clr;
    logic [NREQ-1:0]    w_cap;
    logic [PTR_W-1:0]   w_ptr_next;
    logic               w_ack_fall;
    logic               w_timeout;

    sd_arb_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_pick    (w_pick),
        .o_idx     (w_idx),
        .o_valid   (w_valid)
    );

    assign w_ack_fall = r_ack_q && !sd_ack;
    assign w_ptr_next = (r_idx == PTR_W'(NREQ - 1)) ? '0 : r_idx + PTR_W'(1);
    assign w_clr      = ((r_state == ST_DONE) || w_timeout) ? r_grant : '0;
    // A pulse in the cycle its pending bit clears is accepted (re-arm).
    assign w_cap      = (req_rd | req_wr) & (~r_pending | w_clr);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_lba[i] <= '0;
                r_dir[i] <= DIR_RD;
            end
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_cap;
            for (int i = 0; i < NREQ; i++) begin
                if (w_cap[i]) begin
                    r_lba[i] <= req_lba[i*LBA_W +: LBA_W];
                    r_dir[i] <= req_rd[i] ? DIR_RD : DIR_WR;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_idx    <= '0;
            r_ptr    <= '0;
            r_sd_lba <= '0;
            r_sd_rd  <= '0;
            r_sd_wr  <= '0;
            r_ack_q  <= 1'b0;
        end else begin
            r_ack_q <= sd_ack;
            case (r_state)
                ST_IDLE: begin
                    // A stale sd_ack from hps_io blocks new grants.
                    if (w_valid && !sd_ack) begin
                        r_grant  <= w_pick;
                        r_idx    <= w_idx;
                        r_sd_lba <= 32'(r_lba[w_idx]);
                        r_sd_rd  <= (r_dir[w_idx] == DIR_RD) ? w_pick : '0;
                        r_sd_wr  <= (r_dir[w_idx] == DIR_WR) ? w_pick : '0;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sd_ack) begin
                        r_sd_rd <= '0;
                        r_sd_wr <= '0;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_ack_fall) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_grant <= '0;
                    r_ptr   <= w_ptr_next;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_timeout) begin
                r_sd_rd <= '0;
                r_sd_wr <= '0;
                r_grant <= '0;
                r_ptr   <= w_ptr_next;
                r_state <= ST_IDLE;
            end
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [NREQ-1:0]  r_err;
    logic             w_active;
    logic             w_move;

    assign w_active  = (r_state == ST_ISSUE) || (r_state == ST_XFER);
    assign w_move    = ((r_state == ST_ISSUE) && sd_ack) || ((r_state == ST_XFER) && w_ack_fall);
    assign w_timeout = w_active && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter restarts from zero on every ISSUE/XFER entry.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= '0;
        end else begin
            r_err <= w_timeout ? r_grant : '0;
            if (!w_active || w_move || w_timeout) r_cnt <= '0;
            else                                  r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign req_err = r_err;
`else
    // Watchdog compiled out: never fires, so TIMEOUT_CYCLES has no effect.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
    assign req_err   = '0;
`endif

    assign req_done = (r_state == ST_DONE) ? r_grant : '0;
    assign pending  = r_pending;
    assign grant    = r_grant;
    assign busy     = (r_state != ST_IDLE);
    assign sd_lba   = r_sd_lba;
    assign sd_rd    = r_sd_rd;
    assign sd_wr    = r_sd_wr;

endmodule

// File: tb/tb_sd_req_arbiter.sv
module tb_sd_req_arbiter;

    localparam int NREQ = 3;

    logic              clk_sys = 1'b0;
    logic              reset   = 1'b1;
    logic [NREQ-1:0]   req_rd  = '0;
    logic [NREQ-1:0]   req_wr  = '0;
    logic [NREQ*32-1:0] req_lba = '0;
    logic [NREQ-1:0]   req_done, req_err, pending, grant, sd_rd, sd_wr;
    logic              busy;
    logic [31:0]       sd_lba;
    logic              sd_ack = 1'b0;

    sd_req_arbiter #(.NREQ(NREQ), .LBA_W(32), .TIMEOUT_CYCLES(100)) dut (
        .clk_sys (clk_sys), .reset (reset),
        .req_rd (req_rd), .req_wr (req_wr), .req_lba (req_lba),
        .req_done (req_done), .req_err (req_err), .pending (pending),
        .grant (grant), .busy (busy), .sd_lba (sd_lba),
        .sd_rd (sd_rd), .sd_wr (sd_wr), .sd_ack (sd_ack)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit ack_auto = 1'b0;

    // expected strobe event: {sd_rd, sd_wr, sd_lba, grant}
    logic [40:0] q_x[$];
    logic [2:0]  q_done[$];
    logic [2:0]  q_err[$];

    always @(posedge clk_sys) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_x(input logic [2:0] rd, input logic [2:0] wr, input logic [31:0] lba,
                          input bit with_done);
        q_x.push_back({rd, wr, lba, rd | wr});
        if (with_done) q_done.push_back(rd | wr);
    endtask

    task automatic issue(input logic [2:0] rd, input logic [2:0] wr,
                         input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2);
        @(posedge clk_sys); #1;
        req_rd = rd; req_wr = wr; req_lba = {l2, l1, l0};
        @(posedge clk_sys); #1;
        req_rd = '0; req_wr = '0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while ((busy || pending != '0) && n < budget);
        chk(name, {63'b0, (busy || pending != '0)}, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk_sys); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;
    endtask

    // scoreboard monitor
    logic [2:0] prev_strobe = '0;
    always @(negedge clk_sys) begin
        if (reset) begin
            prev_strobe = '0;
        end else begin
            if ((sd_rd | sd_wr) != '0 && prev_strobe == '0) begin
                if (q_x.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_strobe: rd=%b wr=%b lba=%h required none", sd_rd, sd_wr, sd_lba);
                end else begin
                    chk("strobe{rd,wr,lba,grant}", {23'b0, sd_rd, sd_wr, sd_lba, grant}, {23'b0, q_x.pop_front()});
                end
            end
            prev_strobe = sd_rd | sd_wr;
            if (req_done != '0) begin
                if (q_done.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: req_done=%b required none", req_done);
                end else chk("req_done", {61'b0, req_done}, {61'b0, q_done.pop_front()});
            end
            if (req_err != '0) begin
                if (q_err.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_err: req_err=%b required none", req_err);
                end else chk("req_err", {61'b0, req_err}, {61'b0, q_err.pop_front()});
            end
        end
    end

    // automatic hps_io responder
    initial begin
        forever begin
            @(negedge clk_sys);
            if (ack_auto && (sd_rd | sd_wr) != '0) begin
                repeat (3) @(negedge clk_sys);
                sd_ack = 1'b1;
                repeat (4) @(negedge clk_sys);
                sd_ack = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_grant",   {61'b0, grant},   64'd0);
        chk("rst_pending", {61'b0, pending}, 64'd0);
        chk("rst_busy",    {63'b0, busy},    64'd0);
        chk("rst_strobe",  {58'b0, sd_rd, sd_wr}, 64'd0);
        chk("rst_lba",     {32'b0, sd_lba},  64'd0);
        chk("rst_done_err",{58'b0, req_done, req_err}, 64'd0);
        reset = 1'b0;

        // single read, exact latencies; manual ack high for 21 cycles
        push_x(3'b010, 3'b000, 32'h1234, 1'b1);
        issue(3'b010, 3'b000, 32'h0, 32'h1234, 32'h0);
        @(negedge clk_sys);
        chk("t1_pending_n1", {61'b0, pending}, 64'b010);
        chk("t1_no_strobe_n1", {61'b0, sd_rd}, 64'd0);
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        chk("t1_strobe_n2", {61'b0, sd_rd}, 64'b010);
        chk("t1_grant_n2",  {61'b0, grant}, 64'b010);
        chk("t1_lba_n2",    {32'b0, sd_lba}, 64'h1234);
        repeat (8) @(posedge clk_sys);
        #1 sd_ack = 1'b1;
        @(negedge clk_sys);
        chk("t1_strobe_held", {61'b0, sd_rd}, 64'b010);
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        chk("t1_strobe_dropped", {61'b0, sd_rd}, 64'd0);
        chk("t1_grant_stable",   {61'b0, grant}, 64'b010);
        repeat (20) @(posedge clk_sys);
        #1 sd_ack = 1'b0;
        @(negedge clk_sys);
        chk("t1_done_not_early", {61'b0, req_done}, 64'd0);
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        chk("t1_done_pulse", {61'b0, req_done}, 64'b010);
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        chk("t1_pending_clr", {61'b0, pending}, 64'd0);
        chk("t1_idle", {62'b0, busy, req_done != '0}, 64'd0);

        // round-robin from pointer 0
        do_reset();
        ack_auto = 1'b1;
        push_x(3'b000, 3'b001, 32'hA0, 1'b1);
        push_x(3'b010, 3'b000, 32'hB1, 1'b1);
        push_x(3'b100, 3'b000, 32'hC2, 1'b1);
        issue(3'b110, 3'b001, 32'hA0, 32'hB1, 32'hC2);
        wait_idle(300, "t3_rr_complete");
        push_x(3'b001, 3'b000, 32'h10, 1'b1);
        push_x(3'b100, 3'b000, 32'h12, 1'b1);
        issue(3'b101, 3'b000, 32'h10, 32'h0, 32'h12);
        wait_idle(300, "t3_rr_wrap_complete");

        // collision: write pulse while read pending is dropped
        push_x(3'b001, 3'b000, 32'h5, 1'b1);
        @(posedge clk_sys); #1;
        req_rd = 3'b001; req_lba = {32'h0, 32'h0, 32'h5};
        @(posedge clk_sys); #1;
        req_rd = 3'b000; req_wr = 3'b001; req_lba = {32'h0, 32'h0, 32'h9};
        @(posedge clk_sys); #1;
        req_wr = 3'b000;
        wait_idle(200, "t4_collision_complete");

        // read and write together: read wins
        push_x(3'b010, 3'b000, 32'h77, 1'b1);
        issue(3'b010, 3'b010, 32'h0, 32'h77, 32'h0);
        wait_idle(200, "t5_rdwr_complete");

        // sd_ack already high in IDLE blocks the grant
        ack_auto = 1'b0;
        sd_ack = 1'b1;
        issue(3'b100, 3'b000, 32'h0, 32'h0, 32'hABC);
        repeat (5) @(negedge clk_sys);
        chk("t7_no_grant", {61'b0, grant}, 64'd0);
        chk("t7_not_busy", {63'b0, busy}, 64'd0);
        chk("t7_pending",  {61'b0, pending}, 64'b100);
        push_x(3'b100, 3'b000, 32'hABC, 1'b1);
        ack_auto = 1'b1;
        sd_ack = 1'b0;
        wait_idle(200, "t7_complete");

        // reset in the middle of a transfer
        ack_auto = 1'b0;
        push_x(3'b001, 3'b000, 32'h55, 1'b0);
        issue(3'b001, 3'b000, 32'h55, 32'h0, 32'h0);
        @(posedge clk_sys); #1 sd_ack = 1'b1;
        repeat (3) @(posedge clk_sys);
        #2 reset = 1'b1;
        #1;
        chk("t8_rst_strobe",  {58'b0, sd_rd, sd_wr}, 64'd0);
        chk("t8_rst_grant",   {61'b0, grant},   64'd0);
        chk("t8_rst_pending", {61'b0, pending}, 64'd0);
        chk("t8_rst_busy",    {63'b0, busy},    64'd0);
        sd_ack = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;
        repeat (10) @(negedge clk_sys);
        chk("t8_still_idle", {62'b0, busy, pending != '0}, 64'd0);

`ifdef SD_ARB_TIMEOUT_EN
        begin
            int n;
            int t0;
            push_x(3'b010, 3'b000, 32'h21, 1'b0);
            push_x(3'b000, 3'b100, 32'h22, 1'b0);
            q_err.push_back(3'b010);
            q_err.push_back(3'b100);
            issue(3'b010, 3'b100, 32'h0, 32'h21, 32'h22);
            n = 0;
            do begin @(negedge clk_sys); n++; end while ((sd_rd | sd_wr) == '0 && n < 10);
            t0 = cyc;
            n = 0;
            do begin @(negedge clk_sys); n++; end while (req_err == '0 && n < 200);
            chk("t9_err_latency", 64'(cyc - t0), 64'd100);
            chk("t9_strobe_dropped", {61'b0, sd_rd}, 64'd0);
            wait_idle(300, "t9_second_timeout");
        end
`endif

        repeat (3) @(negedge clk_sys);
        chk("q_strobe_empty", 64'(q_x.size()), 64'd0);
        chk("q_done_empty",   64'(q_done.size()), 64'd0);
        chk("q_err_empty",    64'(q_err.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
